// File: rtl/buffer_sched_pkg.sv
// Shared constants and write-FSM encoding for the activation/weight buffer scheduler.
package buffer_sched_pkg;
   localparam int BUF_DEPTH = 64;
   localparam int BUF_DW    = 16;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_PULSE = 2'd1,
      W_GAP   = 2'd2
   } wstate_t;
endpackage

// File: rtl/buffer_sched_rr_arb2.sv
// Two-input round-robin arbiter: a lone request always wins, a tie goes to ptr.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = req;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/buffer_sched.sv
// Write pacing, read arbitration and clear sequencing in front of the 64x16 buffer.
module buffer_sched
   import buffer_sched_pkg::*;
#(
   parameter  int DEPTH = BUF_DEPTH,
   parameter  int DW    = BUF_DW,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   input  logic [1:0]    rd_req,
   input  logic [AW-1:0] rd_addr0,
   input  logic [AW-1:0] rd_addr1,
   output logic [1:0]    rd_gnt,
   output logic          rd_valid,
   output logic          rd_id,
   output logic [DW-1:0] rd_data,
   output logic [CW-1:0] fill_count,
   output logic          full,
   output logic          buf_reset,
   output logic [AW-1:0] buf_address,
   output logic [DW-1:0] buf_data_in,
   output logic          buf_write_enable,
   output logic          buf_read_enable,
   input  logic [DW-1:0] buf_data_out
);
   wstate_t    state, state_next;
   logic       accept, we_next, halt;
   logic [1:0] elig, arb_gnt;
   logic       rr_ptr;
   logic [2:1] vld_pipe, id_pipe;

   // nothing is consumed while the controller or buffer is being emptied
   assign halt = reset || clear || buf_reset;

   always_ff @(posedge clk) begin
      if (reset) state <= W_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      accept     = 1'b0;
      we_next    = 1'b0;
      case (state)
         W_IDLE: begin
            wr_ready = !full && !halt;
            accept   = wr_valid && wr_ready;
            if (accept) begin
               we_next    = 1'b1;
               state_next = W_PULSE;
            end
         end
         W_PULSE: state_next = W_GAP;
         W_GAP:   state_next = W_IDLE;
         default: state_next = W_IDLE;
      endcase
      if (clear) begin
         state_next = W_IDLE;
         we_next    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_count       <= '0;
         full             <= 1'b0;
         buf_write_enable <= 1'b0;
         buf_data_in      <= '0;
         buf_reset        <= 1'b0;
      end else begin
         buf_write_enable <= we_next;
         buf_reset        <= clear;
         if (accept) buf_data_in <= wr_data;
         if (clear) begin
            fill_count <= '0;
            full       <= 1'b0;
         end else if (state == W_PULSE) begin
            fill_count <= fill_count + CW'(1);
            full       <= (fill_count == CW'(DEPTH - 1));
         end
      end
   end

   // a word becomes readable once the pulse that wrote it has been counted
   assign elig[0] = rd_req[0] && (CW'(rd_addr0) < fill_count);
   assign elig[1] = rd_req[1] && (CW'(rd_addr1) < fill_count);

   rr_arb2 u_arb (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (arb_gnt)
   );

   assign rd_gnt = halt ? 2'b00 : arb_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= 1'b0;
         vld_pipe    <= '0;
         id_pipe     <= '0;
         buf_address <= '0;
      end else begin
         vld_pipe[1] <= |rd_gnt;
         vld_pipe[2] <= vld_pipe[1] && !clear;
         id_pipe[1]  <= rd_gnt[1];
         id_pipe[2]  <= id_pipe[1];
         if (|rd_gnt) begin
            rr_ptr      <= rd_gnt[0];
            buf_address <= rd_gnt[1] ? rd_addr1 : rd_addr0;
         end
      end
   end

   assign buf_read_enable = vld_pipe[1];
   assign rd_valid        = vld_pipe[2];
   assign rd_id           = id_pipe[2];
   // buffer output is already a register; forward it only alongside rd_valid
   assign rd_data         = rd_valid ? buf_data_out : '0;
endmodule

// File: tb/tb_buffer_sched.sv
// Bench for buffer_sched: directed vector table, hand sequences and a randomized run vs. a reference model.
module tb_buffer_sched;
   localparam int DEPTH = 64;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          reset, clear, wr_valid, wr_ready;
   logic [DW-1:0] wr_data, rd_data, buf_data_in, buf_data_out;
   logic [1:0]    rd_req, rd_gnt;
   logic [5:0]    rd_addr0, rd_addr1, buf_address;
   logic          rd_valid, rd_id, full, buf_reset, buf_write_enable, buf_read_enable;
   logic [6:0]    fill_count;

   always #5 clk = ~clk;

   buffer_sched #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
      .fill_count(fill_count), .full(full), .buf_reset(buf_reset),
      .buf_address(buf_address), .buf_data_in(buf_data_in),
      .buf_write_enable(buf_write_enable), .buf_read_enable(buf_read_enable),
      .buf_data_out(buf_data_out)
   );

   // buffer: auto-incrementing write pointer, registered read port
   logic [DW-1:0] mem [DEPTH];
   logic [5:0]    wptr;
   always @(posedge clk) begin
      if (reset || buf_reset) begin
         wptr         <= '0;
         buf_data_out <= '0;
      end else begin
         if (buf_write_enable) begin
            mem[wptr] <= buf_data_in;
            wptr      <= wptr + 6'd1;
         end
         if (buf_read_enable) buf_data_out <= mem[buf_address];
      end
   end

   int nvec = 0, nmis = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // reference model: words accepted since last clear, visible fill, tie preference, pending reads
   typedef struct { int due; bit id; logic [DW-1:0] data; } rd_t;
   logic [DW-1:0] words [DEPTH];
   int  cyc = 0, nacc, fill_m;
   bit  favour, clr_prev, acc_p1, acc_p2, g_prev;
   logic [DW-1:0] accd_p1;
   logic [5:0]    gaddr_prev;
   rd_t rq[$];

   always @(negedge clk) begin : model
      bit rdy, acc, ev;
      bit [1:0] el, g;
      if (reset) begin
         nacc = 0; fill_m = 0; favour = 1'b0; clr_prev = 1'b0;
         acc_p1 = 1'b0; acc_p2 = 1'b0; g_prev = 1'b0; rq.delete();
      end else begin
         // one write per three cycles, never during a clear sequence or when full
         rdy = !clear && !clr_prev && !acc_p1 && !acc_p2 && fill_m < DEPTH;
         chk("wr_ready", 32'(wr_ready), 32'(rdy));
         chk("buf_write_enable", 32'(buf_write_enable), 32'(acc_p1));
         if (acc_p1) chk("buf_data_in", 32'(buf_data_in), 32'(accd_p1));
         chk("buf_reset", 32'(buf_reset), 32'(clr_prev));
         chk("fill_count", 32'(fill_count), 32'(fill_m));
         chk("full", 32'(full), 32'(fill_m == DEPTH));
         el[0] = rd_req[0] && (int'(rd_addr0) < fill_m);
         el[1] = rd_req[1] && (int'(rd_addr1) < fill_m);
         g = 2'b00;
         if (!clear && !clr_prev) g = (el == 2'b11) ? (favour ? 2'b10 : 2'b01) : el;
         chk("rd_gnt", 32'(rd_gnt), 32'(g));
         chk("buf_read_enable", 32'(buf_read_enable), 32'(g_prev));
         if (g_prev) chk("buf_address", 32'(buf_address), 32'(gaddr_prev));
         ev = rq.size() > 0 && rq[0].due == cyc;
         chk("rd_valid", 32'(rd_valid), 32'(ev));
         if (ev) begin
            chk("rd_id", 32'(rd_id), 32'(rq[0].id));
            chk("rd_data", 32'(rd_data), 32'(rq[0].data));
            void'(rq.pop_front());
         end
         acc = wr_valid && rdy;
         if (acc) begin
            words[nacc] = wr_data;
            nacc++;
         end
         g_prev = (g != 2'b00);
         if (g_prev) begin
            favour     = g[0];
            gaddr_prev = g[1] ? rd_addr1 : rd_addr0;
            rq.push_back('{due: cyc + 2, id: g[1], data: words[gaddr_prev]});
         end
         if (clear) begin
            fill_m = 0;
            nacc   = 0;
            while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
         end else if (acc_p1) fill_m++;
         acc_p2 = acc_p1; acc_p1 = acc; accd_p1 = wr_data; clr_prev = clear;
      end
      cyc++;
   end

   typedef struct {
      logic wv; logic [DW-1:0] wd; logic [1:0] rq; logic [5:0] a0, a1;
      logic we; int fill; logic [1:0] gnt; logic rv, rid; logic [DW-1:0] rdata;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int wv, wd, rqv, a0, a1, we, fill, gnt, rv, rid, rdata);
      tbl.push_back('{wv: 1'(wv), wd: 16'(wd), rq: 2'(rqv), a0: 6'(a0), a1: 6'(a1),
                      we: 1'(we), fill: fill, gnt: 2'(gnt), rv: 1'(rv), rid: 1'(rid),
                      rdata: 16'(rdata)});
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
      rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset fill_count", 32'(fill_count), 0);
      chk("reset full", 32'(full), 0);
      chk("reset buf_write_enable", 32'(buf_write_enable), 0);
      chk("reset buf_reset", 32'(buf_reset), 0);
      chk("reset buf_read_enable", 32'(buf_read_enable), 0);
      chk("reset rd_valid", 32'(rd_valid), 0);
      chk("reset wr_ready", 32'(wr_ready), 0);
      step();
      reset = 1'b0;

      //   wv wd      rq a0 a1  we fill gnt rv id rdata
      add(1, 'h0011, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 'h0022, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      add(1, 'h0022, 0, 0, 0,  0, 1, 0, 0, 0, 0);
      add(1, 'h0022, 0, 0, 0,  0, 1, 0, 0, 0, 0);
      add(1, 'h0033, 0, 0, 0,  1, 1, 0, 0, 0, 0);
      add(1, 'h0033, 0, 0, 0,  0, 2, 0, 0, 0, 0);
      add(1, 'h0033, 0, 0, 0,  0, 2, 0, 0, 0, 0);
      add(0, 0,      0, 0, 0,  1, 2, 0, 0, 0, 0);
      add(0, 0,      0, 0, 0,  0, 3, 0, 0, 0, 0);
      add(0, 0,      1, 1, 0,  0, 3, 1, 0, 0, 0);
      add(0, 0,      2, 1, 2,  0, 3, 2, 0, 0, 0);
      add(0, 0,      3, 0, 2,  0, 3, 1, 1, 0, 'h0022);
      add(0, 0,      3, 0, 2,  0, 3, 2, 1, 1, 'h0033);
      add(0, 0,      3, 0, 2,  0, 3, 1, 1, 0, 'h0011);
      add(0, 0,      3, 0, 2,  0, 3, 2, 1, 1, 'h0033);
      add(0, 0,      0, 0, 0,  0, 3, 0, 1, 0, 'h0011);
      add(0, 0,      0, 0, 0,  0, 3, 0, 1, 1, 'h0033);
      add(1, 'h0044, 2, 0, 5,  0, 3, 0, 0, 0, 0);
      add(1, 'h0044, 2, 0, 5,  1, 3, 0, 0, 0, 0);
      add(1, 'h0044, 2, 0, 5,  0, 4, 0, 0, 0, 0);
      add(1, 'h0055, 2, 0, 5,  0, 4, 0, 0, 0, 0);
      add(1, 'h0055, 2, 0, 5,  1, 4, 0, 0, 0, 0);
      add(1, 'h0055, 2, 0, 5,  0, 5, 0, 0, 0, 0);
      add(1, 'h0066, 2, 0, 5,  0, 5, 0, 0, 0, 0);
      add(0, 0,      2, 0, 5,  1, 5, 0, 0, 0, 0);
      add(0, 0,      2, 0, 5,  0, 6, 2, 0, 0, 0);
      add(0, 0,      0, 0, 0,  0, 6, 0, 0, 0, 0);
      add(0, 0,      0, 0, 0,  0, 6, 0, 1, 1, 'h0066);

      foreach (tbl[i]) begin
         wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_req = tbl[i].rq;
         rd_addr0 = tbl[i].a0; rd_addr1 = tbl[i].a1;
         @(negedge clk);
         chk($sformatf("vec%0d we", i), 32'(buf_write_enable), 32'(tbl[i].we));
         chk($sformatf("vec%0d fill", i), 32'(fill_count), 32'(tbl[i].fill));
         chk($sformatf("vec%0d gnt", i), 32'(rd_gnt), 32'(tbl[i].gnt));
         chk($sformatf("vec%0d rv", i), 32'(rd_valid), 32'(tbl[i].rv));
         if (tbl[i].rv) begin
            chk($sformatf("vec%0d rid", i), 32'(rd_id), 32'(tbl[i].rid));
            chk($sformatf("vec%0d rdata", i), 32'(rd_data), 32'(tbl[i].rdata));
         end
         step();
      end

      // fill to capacity with wr_valid held
      rd_req = 2'b00; wr_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         wr_data = 16'($urandom);
         @(negedge clk);
         if (full) break;
         step();
      end
      chk("full reached", 32'(full), 1);
      chk("fill at full", 32'(fill_count), DEPTH);
      step();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("no write when full", 32'(buf_write_enable), 0);
         chk("not ready when full", 32'(wr_ready), 0);
         step();
      end
      wr_valid = 1'b0;

      // clear mid-pulse with a read in flight
      clear = 1'b1; step();
      clear = 1'b0; repeat (2) step();
      wr_valid = 1'b1; wr_data = 16'h1111;
      @(negedge clk); chk("seq ready after clear", 32'(wr_ready), 1);
      step(); wr_valid = 1'b0; repeat (3) step();
      wr_valid = 1'b1; wr_data = 16'h2222; rd_req = 2'b01; rd_addr0 = 6'd0;
      @(negedge clk); chk("seq gnt before clear", 32'(rd_gnt), 1);
      step(); wr_valid = 1'b0; rd_req = 2'b00; clear = 1'b1;
      @(negedge clk); chk("seq pulse at clear", 32'(buf_write_enable), 1);
      chk("seq gnt in clear", 32'(rd_gnt), 0);
      step(); clear = 1'b0; rd_req = 2'b01;
      @(negedge clk);
      chk("seq buf_reset", 32'(buf_reset), 1);
      chk("seq fill cleared", 32'(fill_count), 0);
      chk("seq rd_valid suppressed", 32'(rd_valid), 0);
      chk("seq wr_ready in buf_reset", 32'(wr_ready), 0);
      chk("seq we in buf_reset", 32'(buf_write_enable), 0);
      step(); rd_req = 2'b00; wr_valid = 1'b1; wr_data = 16'h0abc;
      @(negedge clk);
      chk("seq buf_reset one cycle", 32'(buf_reset), 0);
      chk("seq rd_valid still off", 32'(rd_valid), 0);
      chk("seq ready post clear", 32'(wr_ready), 1);
      step(); wr_valid = 1'b0; step();
      rd_req = 2'b01; rd_addr0 = 6'd0;
      @(negedge clk); chk("seq gnt index0", 32'(rd_gnt), 1);
      step(); rd_req = 2'b00; step();
      @(negedge clk);
      chk("seq rd_valid index0", 32'(rd_valid), 1);
      chk("seq rd_data index0", 32'(rd_data), 32'h0abc);
      step();

      // randomized traffic, with one reset in the middle
      for (int k = 0; k < 3000; k++) begin
         int hi;
         hi       = (fill_m + 2 > 63) ? 63 : fill_m + 2;
         reset    = (k == 2000);
         clear    = ($urandom_range(0, 149) == 0);
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = 16'($urandom);
         rd_req   = 2'($urandom);
         rd_addr0 = 6'($urandom_range(0, hi));
         rd_addr1 = 6'($urandom_range(0, hi));
         step();
      end
      reset = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_req = 2'b00;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
